sram_like_arbiter: RTL
======================

Name: sram_like_arbiter

Overview:
- Merges NUM_CH sram-like master channels onto one sram-like memory port. Default: ch0 = instruction fetch, ch1 = data access.
- Sits between mycpu_top's fetch/memory stages and the memory-side bridge. It replaces the fixed single-cycle inst/data SRAM ports with a req/addr_ok/data_ok handshake.
- Supports multiple outstanding requests and returns in-order responses to the issuing channel.
- Arbitration mode is selectable: fixed priority or round-robin.

Parameters:
- NUM_CH, 2: number of master channels (2..8).
- MAX_OUTST, 4: maximum accepted-but-unanswered requests (power of 2, 2..16).
- PRIO_MODE, 0: 0 = fixed priority (highest index wins), 1 = round-robin.
- ID_W, $clog2(NUM_CH): width of a channel-id FIFO entry (derived).

Ports:
- clk  in  1  clock.
- resetn  in  1  synchronous active-low reset.
- ch_req  in  NUM_CH  per-channel request valid.
- ch_wr  in  NUM_CH  per-channel write flag.
- ch_size  in  2*NUM_CH  per-channel size (0 = byte, 1 = half, 2 = word); channel i occupies bits [2i+1:2i].
- ch_addr  in  32*NUM_CH  per-channel address, channel i occupies slice i.
- ch_wdata  in  32*NUM_CH  per-channel write data, channel i occupies slice i.
- ch_addr_ok  out  NUM_CH  request accepted this cycle.
- ch_data_ok  out  NUM_CH  response for this channel this cycle.
- ch_rdata  out  32  read data, broadcast to all channels; valid with ch_data_ok.
- mem_req  out  1  downstream request valid.
- mem_wr  out  1  downstream write flag.
- mem_size  out  2  downstream size.
- mem_addr  out  32  downstream address.
- mem_wdata  out  32  downstream write data.
- mem_addr_ok  in  1  downstream accepted request.
- mem_data_ok  in  1  downstream response, strictly in acceptance order.
- mem_rdata  in  32  downstream read data.
- outst_cnt  out  $clog2(MAX_OUTST)+1  current outstanding count.
- resp_err  out  1  sticky: mem_data_ok arrived with no outstanding request.

Behaviour:
- Reset (resetn low at posedge) clears:
  - cnt = 0, FIFO head/tail = 0, rr_ptr = 0, lock_vld = 0, resp_err = 0.
  - Outputs while held in reset: mem_req = 0, ch_addr_ok = 0, ch_data_ok = 0.
- Reset mid-operation drops all outstanding ids. Late mem_data_ok pulses after reset set resp_err.
- can_issue = (cnt < MAX_OUTST).
- Arbitration (combinational, only when !lock_vld):
  - PRIO_MODE 0: highest-index requesting channel wins.
  - PRIO_MODE 1: first requesting channel at or after rr_ptr, wrapping modulo NUM_CH.
- mem_req = can_issue & (lock_vld | |ch_req). mem_* fields are muxed from the granted channel (locked channel if lock_vld).
- Grant lock: if mem_req is high and mem_addr_ok is low, register lock_vld = 1 and lock_id = the granted id. The grant stays on that channel until acceptance; no switching mid-handshake.
- Masters hold req/addr/wdata stable until addr_ok; the arbiter does not check this.
- Acceptance = mem_req & mem_addr_ok:
  - ch_addr_ok[g] = 1 in the same cycle.
  - Push g into the id FIFO.
  - Clear lock_vld.
  - If PRIO_MODE 1: rr_ptr <= (g+1) mod NUM_CH.
- Response = mem_data_ok & (cnt != 0):
  - ch_data_ok[FIFO head] = 1, ch_rdata = mem_rdata.
  - Pop the head.
  - Applies to writes too: data_ok with ignored rdata.
- mem_data_ok & (cnt == 0): no ch_data_ok, no pop; resp_err <= 1 until reset.
- Simultaneous accept and response in one cycle: cnt unchanged, head and tail both advance.
- Full (cnt == MAX_OUTST): mem_req = 0 even if a lock is pending. Issue resumes the cycle after a pop. No same-cycle pop-to-push bypass, which keeps data_ok off the req path.
- FIFO pointers are ID_W-wide entries, $clog2(MAX_OUTST)-bit indices, wrapping naturally.
- Latency: zero-cycle combinational pass-through on request; zero-cycle response routing. No internal data buffering.

Decomposition:
- Shared package/header (alongside the existing bus-width defines):
  - SRAM_SIZE_BYTE/HALF/WORD constants.
  - PRIO_FIXED/PRIO_RR constants.
- One sub-module: sram_like_id_fifo (depth MAX_OUTST, width ID_W, push/pop/count). Reusable later for cache miss queues.

Test Plan:
- Single read: ch0 req addr 0xBFC00000, mem_addr_ok same cycle, mem_data_ok 3 cycles later with rdata 0x3C080001 -> ch0 addr_ok at cycle 0, ch0 data_ok with rdata 0x3C080001 at cycle 3, outst_cnt back to 0.
- Fixed priority: ch0 and ch1 both request, PRIO_MODE 0 -> ch1 accepted first, ch0 next. Responses 0xAAAA0001 then 0xBBBB0002 route to ch1 then ch0.
- Lock and round-robin: PRIO_MODE 1, mem_addr_ok low 2 cycles while ch0 and ch1 request -> mem_addr stays ch0's (rr_ptr = 0) for all 3 cycles. After accept, rr_ptr = 1 and the next grant goes to ch1.
- Full: MAX_OUTST = 4, issue 4 reads with no data_ok -> mem_req = 0 and outst_cnt = 4. One data_ok -> mem_req re-asserts the next cycle.
- Simultaneous: cnt = 2, accept and mem_data_ok in the same cycle -> cnt stays 2, and the oldest id gets data_ok.
- Error and reset: mem_data_ok with cnt = 0 -> resp_err = 1, no ch_data_ok. Reset mid-burst (cnt = 3) -> cnt = 0, resp_err = 0, mem_req = 0 next cycle.

Source files
------------

// File: rtl/sram_like_arbiter_pkg.sv
// sram_like_arbiter shared constants.
// Transfer sizes, arbitration modes and a small wrap helper.
package sram_like_arbiter_pkg;

  localparam logic [1:0] SRAM_SIZE_BYTE = 2'd0;
  localparam logic [1:0] SRAM_SIZE_HALF = 2'd1;
  localparam logic [1:0] SRAM_SIZE_WORD = 2'd2;

  localparam int PRIO_FIXED = 0;
  localparam int PRIO_RR    = 1;

  function automatic int wrap_inc(input int v, input int n);
    return (v + 1 >= n) ? 0 : v + 1;
  endfunction

endpackage

// File: rtl/sram_like_id_fifo.sv
// sram_like_id_fifo: small circular FIFO of channel ids.
// The caller guarantees no push when full and no pop when empty.
module sram_like_id_fifo
  import sram_like_arbiter_pkg::*;
#(
  parameter  int DEPTH = 4,
  parameter  int W     = 1,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          push,
  input  logic [W-1:0]  din,
  input  logic          pop,
  output logic [W-1:0]  dout,
  output logic [CW-1:0] count
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] head;
  logic [AW-1:0] tail;

  always_ff @(posedge clk) begin
    if (push) mem[tail] <= din;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + 1'b1;
      if (pop)  head <= head + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign dout = mem[head];

endmodule

// File: rtl/sram_like_arbiter.sv
// sram_like_arbiter: merges NUM_CH sram-like masters onto one port.
// Responses return in order to the issuing channel via an id FIFO.
module sram_like_arbiter
  import sram_like_arbiter_pkg::*;
#(
  parameter  int NUM_CH    = 2,
  parameter  int MAX_OUTST = 4,
  parameter  int PRIO_MODE = PRIO_FIXED,
  localparam int ID_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int CNT_W     = $clog2(MAX_OUTST) + 1
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic [NUM_CH-1:0]      ch_req,
  input  logic [NUM_CH-1:0]      ch_wr,
  input  logic [2*NUM_CH-1:0]    ch_size,
  input  logic [32*NUM_CH-1:0]   ch_addr,
  input  logic [32*NUM_CH-1:0]   ch_wdata,
  output logic [NUM_CH-1:0]      ch_addr_ok,
  output logic [NUM_CH-1:0]      ch_data_ok,
  output logic [31:0]            ch_rdata,
  output logic                   mem_req,
  output logic                   mem_wr,
  output logic [1:0]             mem_size,
  output logic [31:0]            mem_addr,
  output logic [31:0]            mem_wdata,
  input  logic                   mem_addr_ok,
  input  logic                   mem_data_ok,
  input  logic [31:0]            mem_rdata,
  output logic [CNT_W-1:0]       outst_cnt,
  output logic                   resp_err
);

  logic [CNT_W-1:0] cnt;
  logic             lock_vld;
  logic [ID_W-1:0]  lock_id;
  logic [ID_W-1:0]  rr_ptr;
  logic [ID_W-1:0]  arb_id;
  logic [ID_W-1:0]  gnt_id;
  logic [ID_W-1:0]  head_id;
  logic             can_issue;
  logic             accept;
  logic             resp;

  // Later loop iterations override earlier ones, so ordering sets priority.
  always_comb begin
    arb_id = '0;
    if (PRIO_MODE == PRIO_RR) begin
      for (int k = NUM_CH - 1; k >= 0; k--) begin
        if (ch_req[(int'(rr_ptr) + k) % NUM_CH])
          arb_id = ID_W'((int'(rr_ptr) + k) % NUM_CH);
      end
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (ch_req[i]) arb_id = ID_W'(i);
      end
    end
  end

  assign can_issue = (cnt < CNT_W'(MAX_OUTST));
  assign gnt_id    = lock_vld ? lock_id : arb_id;
  assign mem_req   = resetn & can_issue & (lock_vld | (|ch_req));
  assign mem_wr    = ch_wr[gnt_id];
  assign mem_size  = ch_size[2*int'(gnt_id) +: 2];
  assign mem_addr  = ch_addr[32*int'(gnt_id) +: 32];
  assign mem_wdata = ch_wdata[32*int'(gnt_id) +: 32];
  assign accept    = mem_req & mem_addr_ok;
  assign resp      = resetn & mem_data_ok & (cnt != '0);
  assign ch_rdata  = mem_rdata;
  assign outst_cnt = cnt;

  always_comb begin
    ch_addr_ok = '0;
    ch_data_ok = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      ch_addr_ok[i] = accept && (gnt_id == ID_W'(i));
      ch_data_ok[i] = resp && (head_id == ID_W'(i));
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      lock_vld <= 1'b0;
      lock_id  <= '0;
      rr_ptr   <= '0;
      resp_err <= 1'b0;
    end else begin
      if (accept) begin
        lock_vld <= 1'b0;
      end else if (mem_req) begin
        lock_vld <= 1'b1;
        lock_id  <= gnt_id;
      end
      if (accept && PRIO_MODE == PRIO_RR)
        rr_ptr <= ID_W'(wrap_inc(int'(gnt_id), NUM_CH));
      if (mem_data_ok && cnt == '0)
        resp_err <= 1'b1;
    end
  end

  sram_like_id_fifo #(
    .DEPTH (MAX_OUTST),
    .W     (ID_W)
  ) u_id_fifo (
    .clk    (clk),
    .resetn (resetn),
    .push   (accept),
    .din    (gnt_id),
    .pop    (resp),
    .dout   (head_id),
    .count  (cnt)
  );

endmodule
